// File: rtl/cpu_state_sequencer.sv
// cpu_state_sequencer: HALT/FETCH/DECODE/EXEC1/EXEC2 phase sequencer; define CPU_PERF_COUNT_EN to build the perf counters.
// Latency 4 cycles FETCH->commit, +1 per waitrequest cycle; a request seeing waitrequest holds the current phase.
module cpu_state_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] pc_next,
  output logic [3:0]  state,
  output logic        active,
  output logic        stall,
  output logic        commit,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count,
  output logic [31:0] stall_count
);

  typedef enum logic [3:0] {
    HALT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC1  = 4'd3,
    EXEC2  = 4'd4
  } state_t;

  logic [3:0] state_r;
  logic [3:0] state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= FETCH;
    else       state_r <= state_d;
  end

  // Gated by reset so an in-flight request cannot report a stall while state is being forced.
  assign stall  = ~reset & (memread | memwrite) & waitrequest & (state_r != HALT);
  assign commit = ~reset & (state_r == EXEC2) & ~stall;
  assign active = (state_r != HALT);
  assign state  = state_r;

  always_comb begin
    state_d = state_r;
    case (state_r)
      HALT:   state_d = HALT;
      FETCH:  if (!stall) state_d = DECODE;
      DECODE: if (!stall) state_d = EXEC1;
      EXEC1:  if (!stall) state_d = EXEC2;
      EXEC2:  if (!stall) state_d = (pc_next == 32'h0000_0000) ? HALT : FETCH;
      default: state_d = HALT;
    endcase
  end

`ifdef CPU_PERF_COUNT_EN
  logic [31:0] cycle_q;
  logic [31:0] instr_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= 32'h0;
      instr_q <= 32'h0;
      stall_q <= 32'h0;
    end else begin
      if (active) cycle_q <= cycle_q + 32'd1;
      if (commit) instr_q <= instr_q + 32'd1;
      if (stall)  stall_q <= stall_q + 32'd1;
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  assign stall_count = stall_q;
`else
  assign cycle_count = 32'h0;
  assign instr_count = 32'h0;
  assign stall_count = 32'h0;
`endif

endmodule

// File: doc/cpu_state_sequencer.md
CPU_STATE_SEQUENCER -- requirements
Module: cpu_state_sequencer

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 SHALL expose these ports, clock and reset first:
- clk, in, 1: sole clock; all state updates on rising edge.
- reset, in, 1: asynchronous active-high reset.
- waitrequest, in, 1: Avalon waitrequest from memory.
- memread, in, 1: read request from control unit, current cycle.
- memwrite, in, 1: write request from control unit, current cycle.
- pc_next, in, 32: PC value the datapath will load on commit.
- state, out, 4: current phase, feeds control unit `state`.
- active, out, 1: high while not in HALT.
- stall, out, 1: current phase held this cycle.
- commit, out, 1: instruction retires this cycle; gates PC write.
- cycle_count, out, 32: performance counter (see Configuration).
- instr_count, out, 32: performance counter (see Configuration).
- stall_count, out, 32: performance counter (see Configuration).

Function
REQ-003 SHALL encode state as HALT=4'd0, FETCH=4'd1, DECODE=4'd2, EXEC1=4'd3, EXEC2=4'd4.
REQ-004 SHALL drive stall = (memread | memwrite) & waitrequest & (state != HALT), combinationally.
REQ-005 SHALL hold state unchanged on any edge where stall is high.
REQ-006 With stall low, SHALL transition FETCH->DECODE->EXEC1->EXEC2, one step per clock.
REQ-007 From EXEC2 with stall low, SHALL go to HALT if pc_next==32'h0000_0000, else to FETCH.
REQ-008 SHALL drive commit = (state==EXEC2) & ~stall; the datapath SHALL use commit, not raw EXEC2, to write PC.
REQ-009 A stalled EXEC2 (e.g. sw waiting on waitrequest) SHALL produce exactly one commit cycle per instruction.
REQ-010 Once in HALT, SHALL remain in HALT until reset, regardless of waitrequest, memread or memwrite.
REQ-011 Illegal encodings 4'd5..4'd15 SHALL transition to HALT on the next edge, ignoring stall.
REQ-012 SHALL drive active = (state != HALT).
REQ-013 Minimum instruction latency SHALL be 4 cycles, FETCH to commit inclusive; each waitrequest cycle adds one.
REQ-014 waitrequest high with memread and memwrite both low SHALL NOT stall.
REQ-015 SHALL NOT register waitrequest; the stall decision is same-cycle.

Reset
REQ-016 Asserting reset SHALL immediately force state=FETCH, active=1 and all counters to 0, independent of clk.
REQ-017 Reset asserted mid-instruction (any phase, stalled or not) SHALL abandon that instruction with no commit.
REQ-018 After reset deasserts, the first rising edge SHALL evaluate FETCH normally, including stall.
REQ-019 While reset is high, commit SHALL be 0 and stall SHALL be 0.

Configuration
REQ-020 Macro CPU_PERF_COUNT_EN SHALL compile the performance counters in or out.
REQ-021 With the macro defined, the counters SHALL behave as follows, all 32-bit and wrapping 32'hFFFF_FFFF->0:
- cycle_count increments every edge while active.
- instr_count increments on each commit.
- stall_count increments each edge where stall=1.
REQ-022 With the macro undefined, the counter ports SHALL remain present and be tied to 32'h0, with no counter flops.
REQ-023 Sequencing behaviour (REQ-003..REQ-019) SHALL be identical with or without the macro.

Verification
REQ-024 Reset pulse, memread=1 in FETCH and EXEC1, waitrequest=0, pc_next=32'hBFC0_0004 -> state 1,2,3,4,1; commit high only on the state=4 cycle; instr_count=1.
REQ-025 waitrequest=1 for 3 cycles during FETCH with memread=1 -> state stays 1 for 4 cycles; stall high for 3; stall_count=3; total latency 7 cycles.
REQ-026 sw with memwrite=1 in EXEC2 and waitrequest=1 for 2 cycles -> state 4 held 3 cycles; commit high exactly once, on the 3rd cycle.
REQ-027 Commit with pc_next=32'h0 -> state=0 and active=0 next edge; 10 further edges with memread=1 and waitrequest toggling leave state=0 and cycle_count frozen.
REQ-028 Reset asserted asynchronously mid-EXEC1 while stalled -> state=1 before the next clk edge; counters=0; no commit pulse.
REQ-029 Force state to 4'd9 -> HALT next edge; with CPU_PERF_COUNT_EN undefined, all counters read 0 throughout every scenario.
